// File: rtl/tone_bank_if.sv
// Command channel for tone_bank: valid/ready handshake plus the note fields and the reject pulse.
interface tone_bank_if #(
    parameter int VOICES = 4,
    parameter int OCT_W  = 3
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [VW-1:0]           cmd_voice;
    logic                    cmd_on;
    logic [3:0]              cmd_note;
    logic signed [OCT_W-1:0] cmd_oct;
    logic                    cmd_err;

    modport master (
        output cmd_valid, cmd_voice, cmd_on, cmd_note, cmd_oct,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_voice, cmd_on, cmd_note, cmd_oct,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/tone_bank.sv
// Bank of square-wave tone voices driven by a 2-stage note command pipeline.
// Optional macro TONE_BANK_PHASE_SYNC_EN: note-on to a sounding voice retriggers it immediately.
module tone_bank #(
    parameter int VOICES = 4,
    parameter int CNT_W  = 24,
    parameter int OCT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    tone_bank_if.slave        cmd,
    output logic [VOICES-1:0] tone,
    output logic [VOICES-1:0] active
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int WW = CNT_W + 8;
    localparam logic [CNT_W-1:0] T_MAX = '1;

    function automatic logic [9:0] half_period(input logic [3:0] idx);
        case (idx)
            4'd0:    return 10'd631;
            4'd1:    return 10'd596;
            4'd2:    return 10'd562;
            4'd3:    return 10'd531;
            4'd4:    return 10'd501;
            4'd5:    return 10'd473;
            4'd6:    return 10'd446;
            4'd7:    return 10'd421;
            4'd8:    return 10'd398;
            4'd9:    return 10'd375;
            4'd10:   return 10'd354;
            4'd11:   return 10'd334;
            default: return 10'd0;
        endcase
    endfunction

    logic                    s1_vld_q, s1_vld_d, s1_on_q, s1_on_d;
    logic [VW-1:0]           s1_voice_q, s1_voice_d;
    logic [3:0]              s1_note_q, s1_note_d;
    logic [OCT_W-1:0]        s1_oct_q, s1_oct_d;
    logic                    s2_vld_q, s2_vld_d, s2_ok_q, s2_ok_d, s2_on_q, s2_on_d;
    logic [VW-1:0]           s2_voice_q, s2_voice_d;
    logic [9:0]              s2_base_q, s2_base_d;
    logic [OCT_W-1:0]        s2_oct_q, s2_oct_d;
    logic                    err_q, err_d;

    logic [CNT_W-1:0] cnt_q  [VOICES];
    logic [CNT_W-1:0] cnt_d  [VOICES];
    logic [CNT_W-1:0] term_q [VOICES];
    logic [CNT_W-1:0] term_d [VOICES];
    logic [CNT_W-1:0] pend_q [VOICES];
    logic [CNT_W-1:0] pend_d [VOICES];
    logic [VOICES-1:0] tone_q, tone_d, active_q, active_d, rel_q, rel_d;

    logic             s1_bad;
    logic [WW-1:0]    base_w, shl, shr;
    logic [OCT_W:0]   rsh;
    logic [CNT_W-1:0] t_new;

    assign cmd.cmd_ready = ~(s1_vld_q | s2_vld_q);
    assign cmd.cmd_err   = err_q;
    assign tone          = tone_q;
    assign active        = active_q;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        s1_vld_d   = cmd.cmd_valid & cmd.cmd_ready;
        s1_voice_d = s1_voice_q;
        s1_on_d    = s1_on_q;
        s1_note_d  = s1_note_q;
        s1_oct_d   = s1_oct_q;
        if (s1_vld_d) begin
            s1_voice_d = cmd.cmd_voice;
            s1_on_d    = cmd.cmd_on;
            s1_note_d  = cmd.cmd_note;
            s1_oct_d   = cmd.cmd_oct;
        end

        s1_bad     = (s1_note_q > 4'd11) || (int'(s1_voice_q) >= VOICES);
        s2_vld_d   = s1_vld_q;
        s2_ok_d    = s1_vld_q & ~s1_bad;
        err_d      = s1_vld_q & s1_bad;
        s2_voice_d = s1_voice_q;
        s2_on_d    = s1_on_q;
        s2_oct_d   = s1_oct_q;
        s2_base_d  = half_period(s1_note_q);
    end

    // Octave shift; a left shift that loses bits or exceeds the counter range saturates.
    always_comb begin
        base_w = WW'(s2_base_q);
        shl    = base_w << $unsigned(s2_oct_q);
        rsh    = -{s2_oct_q[OCT_W-1], s2_oct_q};
        shr    = base_w >> rsh;
        t_new  = T_MAX;
        if (!s2_oct_q[OCT_W-1]) begin
            if (((shl >> $unsigned(s2_oct_q)) == base_w) && (shl <= WW'(T_MAX)))
                t_new = shl[CNT_W-1:0];
        end else begin
            t_new = (shr == '0) ? CNT_W'(1) : shr[CNT_W-1:0];
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        term_d   = term_q;
        pend_d   = pend_q;
        tone_d   = tone_q;
        active_d = active_q;
        rel_d    = rel_q;
        for (int v = 0; v < VOICES; v++) begin
            logic wr, wr_on, rel_eff;
            wr      = s2_ok_q && (s2_voice_q == VW'(v));
            wr_on   = wr & s2_on_q;
            rel_eff = rel_q[v] & ~wr_on;
            if (active_q[v]) begin
                if (cnt_q[v] == term_q[v]) begin
                    // Terminal event: the period change takes effect only here, from the old pending value.
                    cnt_d[v]  = '0;
                    term_d[v] = pend_q[v];
                    if (rel_eff && tone_q[v]) begin
                        tone_d[v]   = 1'b0;
                        active_d[v] = 1'b0;
                        rel_d[v]    = 1'b0;
                    end else begin
                        tone_d[v] = ~tone_q[v];
                    end
                end else begin
                    cnt_d[v] = cnt_q[v] + CNT_W'(1);
                end
            end

            if (wr_on) begin
                pend_d[v] = t_new;
                rel_d[v]  = 1'b0;
                if (!active_q[v]) begin
                    active_d[v] = 1'b1;
                    term_d[v]   = t_new;
                    cnt_d[v]    = '0;
                    tone_d[v]   = 1'b0;
                end
`ifdef TONE_BANK_PHASE_SYNC_EN
                else if (!rel_q[v]) begin
                    term_d[v] = t_new;
                    cnt_d[v]  = '0;
                    tone_d[v] = 1'b0;
                end
`endif
            end else if (wr && active_d[v]) begin
                rel_d[v] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in the _d blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_voice_q <= '0;
            s1_on_q    <= 1'b0;
            s1_note_q  <= '0;
            s1_oct_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_ok_q    <= 1'b0;
            s2_voice_q <= '0;
            s2_on_q    <= 1'b0;
            s2_base_q  <= '0;
            s2_oct_q   <= '0;
            err_q      <= 1'b0;
            tone_q     <= '0;
            active_q   <= '0;
            rel_q      <= '0;
            // NOTE: the per-voice arrays are a handful of registers, not RAM, so they are cleared like any flop.
            for (int v = 0; v < VOICES; v++) begin
                cnt_q[v]  <= '0;
                term_q[v] <= '0;
                pend_q[v] <= '0;
            end
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_voice_q <= s1_voice_d;
            s1_on_q    <= s1_on_d;
            s1_note_q  <= s1_note_d;
            s1_oct_q   <= s1_oct_d;
            s2_vld_q   <= s2_vld_d;
            s2_ok_q    <= s2_ok_d;
            s2_voice_q <= s2_voice_d;
            s2_on_q    <= s2_on_d;
            s2_base_q  <= s2_base_d;
            s2_oct_q   <= s2_oct_d;
            err_q      <= err_d;
            tone_q     <= tone_d;
            active_q   <= active_d;
            rel_q      <= rel_d;
            cnt_q      <= cnt_d;
            term_q     <= term_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank: bank A uses default parameters, bank B uses VOICES=3, CNT_W=10, OCT_W=5.
module tb_tone_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tone_bank_if #(.VOICES(4), .OCT_W(3)) bus_a ();
    tone_bank_if #(.VOICES(3), .OCT_W(5)) bus_b ();
    logic [3:0] tone_a, active_a;
    logic [2:0] tone_b, active_b;

    tone_bank #(.VOICES(4), .CNT_W(24), .OCT_W(3)) dut_a (
        .clk(clk), .rst(rst), .cmd(bus_a), .tone(tone_a), .active(active_a)
    );
    tone_bank #(.VOICES(3), .CNT_W(10), .OCT_W(5)) dut_b (
        .clk(clk), .rst(rst), .cmd(bus_b), .tone(tone_b), .active(active_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tone_of(input bit b, input int v);
        return b ? tone_b[v] : tone_a[v];
    endfunction

    function automatic logic ready_of(input bit b);
        return b ? bus_b.cmd_ready : bus_a.cmd_ready;
    endfunction

    function automatic logic err_of(input bit b);
        return b ? bus_b.cmd_err : bus_a.cmd_err;
    endfunction

    // Presents one command and lets the accepting edge pass.
    task automatic drive(input bit b, input int voice, input bit on, input int note, input int oct);
        if (!b) begin
            bus_a.cmd_valid = 1'b1;
            bus_a.cmd_voice = 2'(voice);
            bus_a.cmd_on    = on;
            bus_a.cmd_note  = 4'(note);
            bus_a.cmd_oct   = 3'(oct);
        end else begin
            bus_b.cmd_valid = 1'b1;
            bus_b.cmd_voice = 2'(voice);
            bus_b.cmd_on    = on;
            bus_b.cmd_note  = 4'(note);
            bus_b.cmd_oct   = 5'(oct);
        end
        tick();
        bus_a.cmd_valid = 1'b0;
        bus_b.cmd_valid = 1'b0;
    endtask

    // Full command: checks ready low for two cycles and the err pulse only in the second.
    task automatic send(input bit b, input int voice, input bit on, input int note, input int oct,
                        input bit exp_err, input string tag);
        drive(b, voice, on, note, oct);
        check({tag, "/rdy1"}, ready_of(b), 0);
        check({tag, "/err1"}, err_of(b), 0);
        tick();
        check({tag, "/rdy2"}, ready_of(b), 0);
        check({tag, "/err2"}, err_of(b), exp_err);
        tick();
        check({tag, "/rdy3"}, ready_of(b), 1);
        check({tag, "/err3"}, err_of(b), 0);
    endtask

    // Cycles until the tone reaches val; limit+1 on timeout so the caller's check fails.
    task automatic wait_tone(input bit b, input int v, input logic val, input int limit, output int n);
        n = 0;
        while (tone_of(b, v) !== val && n <= limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, t0;
        logic hi;
        rst = 1'b1;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_voice = '0; bus_a.cmd_on = 1'b0; bus_a.cmd_note = '0; bus_a.cmd_oct = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_voice = '0; bus_b.cmd_on = 1'b0; bus_b.cmd_note = '0; bus_b.cmd_oct = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst/tone_a", tone_a, 0);
        check("rst/active_a", active_a, 0);
        check("rst/ready_a", bus_a.cmd_ready, 1);
        check("rst/err_a", bus_a.cmd_err, 0);
        check("rst/active_b", active_b, 0);

        // Basic note: T=631, half-period 632.
        send(0, 0, 1, 0, 0, 0, "on0");
        check("on0/active", active_a, 4'b0001);
        check("on0/tone", tone_a, 0);
        wait_tone(0, 0, 1, 700, n);
        check("on0/hp_rise", n, 632);
        wait_tone(0, 0, 0, 700, n);
        check("on0/hp_fall", n, 632);

        // Mid-period change to note 11 oct +1: T=668.
        wait_tone(0, 0, 1, 700, n);
        check("chg/hp_pre", n, 632);
        t0 = cyc;
        repeat (100) tick();
        send(0, 0, 1, 11, 1, 0, "chg");
`ifdef TONE_BANK_PHASE_SYNC_EN
        check("chg/sync_tone", tone_a[0], 0);
`else
        wait_tone(0, 0, 0, 700, n);
        check("chg/old_half", cyc - t0, 632);
`endif
        wait_tone(0, 0, 1, 800, n);
        check("chg/new_rise", n, 669);
        wait_tone(0, 0, 0, 800, n);
        check("chg/new_fall", n, 669);

        // Note-off while high: ends at the falling event.
        wait_tone(0, 0, 1, 800, n);
        check("offhi/rise", n, 669);
        repeat (50) tick();
        send(0, 0, 0, 0, 0, 0, "offhi");
        check("offhi/still_on", active_a[0], 1);
        wait_tone(0, 0, 0, 800, n);
        check("offhi/fall", n, 616);
        check("offhi/active", active_a[0], 0);
        hi = 1'b0;
        repeat (1500) begin
            tick();
            hi = hi | tone_a[0] | active_a[0];
        end
        check("offhi/quiet", hi, 0);

        // Note-off while low: one full high phase, then stop.
        send(0, 1, 1, 0, 0, 0, "offlo_on");
        t0 = cyc;
        send(0, 1, 0, 0, 0, 0, "offlo_off");
        wait_tone(0, 1, 1, 700, n);
        check("offlo/rise", cyc - t0, 632);
        check("offlo/active_hi", active_a[1], 1);
        wait_tone(0, 1, 0, 700, n);
        check("offlo/fall", n, 632);
        check("offlo/active_lo", active_a[1], 0);

        // Rejected commands.
        send(0, 2, 1, 12, 0, 1, "badnote");
        check("badnote/active", active_a, 0);
        check("badnote/tone", tone_a, 0);
        send(1, 3, 1, 0, 0, 1, "badvoice");
        check("badvoice/active", active_b, 0);

        // Saturation and right-shift clamps on bank B (CNT_W=10).
        send(1, 0, 1, 0, 15, 0, "sat");
        wait_tone(1, 0, 1, 1100, n);
        check("sat/hp", n, 1024);
        send(1, 1, 1, 11, -4, 0, "rsh4");
        wait_tone(1, 1, 1, 100, n);
        check("rsh4/rise", n, 21);
        wait_tone(1, 1, 0, 100, n);
        check("rsh4/fall", n, 21);
        send(1, 2, 1, 11, -12, 0, "rsh12");
        wait_tone(1, 2, 1, 100, n);
        check("rsh12/rise", n, 2);
        wait_tone(1, 2, 0, 100, n);
        check("rsh12/fall", n, 2);
        check("rsh/active_b", active_b, 3'b111);

        // Reset during stage 1 of a command that would be rejected.
        send(0, 0, 1, 0, 0, 0, "pre_rst");
        drive(0, 3, 1, 12, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst/tone_a", tone_a, 0);
        check("midrst/active_a", active_a, 0);
        check("midrst/active_b", active_b, 0);
        check("midrst/ready", bus_a.cmd_ready, 1);
        check("midrst/err0", bus_a.cmd_err, 0);
        tick();
        check("midrst/err1", bus_a.cmd_err, 0);
        tick();
        check("midrst/err2", bus_a.cmd_err, 0);
        send(0, 3, 1, 0, 0, 0, "post_rst");
        check("post_rst/active", active_a, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
